// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x32 general-purpose register file.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_32x32_if.sv
// Write/read bus of the register file; master drives addresses and write data.
interface reg_file_32x32_if;
  import regfile_pkg::*;

  logic        we;
  reg_addr_t   waddr;
  word_t       wdata;
  reg_addr_t   raddr1;
  reg_addr_t   raddr2;
  word_t       rdata1;
  word_t       rdata2;
  logic [15:0] wr_count;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2, wr_count
  );

endinterface

// File: rtl/reg_file_32x32_read_port.sv
// One combinational read port: decode, zero-register force and, with
// REGFILE_WRITE_BYPASS_EN defined, same-cycle write-through forwarding.
module regfile_read_port
  import regfile_pkg::*;
(
  input  word_t     regs [NREGS],
  input  reg_addr_t raddr,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic      fwd_en,
  input  reg_addr_t waddr,
  input  word_t     wdata,
`endif
  output word_t     rdata
);

  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (fwd_en && (raddr == waddr)) begin
      rdata = wdata;
    end
`endif
    // Checked last so register 0 can never be forwarded
    if (raddr == ZERO_REG) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero. Optional macro: REGFILE_WRITE_BYPASS_EN.
module reg_file_32x32
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reg_file_32x32_if.slave  bus
);

  word_t       regs [NREGS];
  logic [15:0] wr_count_q;
  logic        wr_fire;

  // Only an explicit 1 on we commits; X or 0 falls through as no write
  always_comb begin
    wr_fire = 1'b0;
    if (bus.we) begin
      wr_fire = (bus.waddr != ZERO_REG);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs       <= '{default: '0};
      wr_count_q <= '0;
    end else if (wr_fire) begin
      regs[bus.waddr] <= bus.wdata;
      if (wr_count_q != '1) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign bus.wr_count = wr_count_q;

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd_en;

  // Reset dominates the write, so it must also suppress forwarding
  assign fwd_en = wr_fire && !reset;

  regfile_read_port u_port_a (
    .regs  (regs),
    .raddr (bus.raddr1),
    .fwd_en(fwd_en),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .rdata (bus.rdata1)
  );

  regfile_read_port u_port_b (
    .regs  (regs),
    .raddr (bus.raddr2),
    .fwd_en(fwd_en),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .rdata (bus.rdata2)
  );
`else
  regfile_read_port u_port_a (
    .regs  (regs),
    .raddr (bus.raddr1),
    .rdata (bus.rdata1)
  );

  regfile_read_port u_port_b (
    .regs  (regs),
    .raddr (bus.raddr2),
    .rdata (bus.rdata2)
  );
`endif

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: stimulus queues expectations, a monitor
// compares them against the read ports, wr_count and a bench-side operand mux.
module tb_reg_file_32x32;
  import regfile_pkg::*;

  typedef struct {
    string       name;
    int unsigned sel;   // 0 rdata1, 1 rdata2, 2 wr_count, 3 mux out
    logic [31:0] exp;
  } chk_t;

  logic  clk;
  logic  reset;
  logic  mux_sel;
  word_t mux_in2;
  word_t mux_out;
  chk_t  sb [$];
  event  chk_ev;
  int unsigned n_checks;
  int unsigned n_errors;

  reg_file_32x32_if bus ();

  reg_file_32x32 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Downstream operand select: sel=0 picks port A, sel=1 the immediate
  assign mux_out = mux_sel ? mux_in2 : bus.rdata1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drains the scoreboard each time stimulus presents an observation
  initial begin
    logic [31:0] act;
    chk_t c;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.sel)
          0:       act = bus.rdata1;
          1:       act = bus.rdata2;
          2:       act = {16'h0, bus.wr_count};
          default: act = mux_out;
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
        end
      end
    end
  end

  task automatic expect_v(input string n, input int unsigned s, input logic [31:0] e);
    #1;
    sb.push_back('{name: n, sel: s, exp: e});
    -> chk_ev;
    #1;
  endtask

  task automatic write_reg(input reg_addr_t a, input word_t d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  initial begin
    logic [31:0] raw_pre;
`ifdef REGFILE_WRITE_BYPASS_EN
    raw_pre = 32'h2;
`else
    raw_pre = 32'h1;
`endif
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    mux_sel    = 1'b0;
    mux_in2    = 32'h0;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd5;

    expect_v("reset_rdata1", 0, 32'h0);
    expect_v("reset_rdata2", 1, 32'h0);
    expect_v("reset_count",  2, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    write_reg(5'd5, 32'hFFFF_FFFF);
    bus.raddr1 = 5'd5;
    expect_v("basic_rdata1", 0, 32'hFFFF_FFFF);
    expect_v("basic_count",  2, 32'd1);

    write_reg(5'd0, 32'hDEAD_BEEF);
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    expect_v("zero_rdata1", 0, 32'h0);
    expect_v("zero_rdata2", 1, 32'h0);
    expect_v("zero_count",  2, 32'd1);

    write_reg(5'd7, 32'h1);
    @(negedge clk);
    bus.we     = 1'b1;
    bus.waddr  = 5'd7;
    bus.wdata  = 32'h2;
    bus.raddr1 = 5'd7;
    bus.raddr2 = 5'd0;
    expect_v("raw_before_edge", 0, raw_pre);
    expect_v("raw_r0_port_b",   1, 32'h0);
    @(posedge clk);
    expect_v("raw_after_edge", 0, 32'h2);
    expect_v("raw_count",      2, 32'd3);

    @(negedge clk);
    bus.waddr  = 5'd0;
    bus.wdata  = 32'hDEAD_BEEF;
    bus.raddr1 = 5'd0;
    expect_v("r0_no_bypass", 0, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    expect_v("r0_write_count", 2, 32'd3);

    write_reg(5'd3, 32'hFFFF_FFFF);
    write_reg(5'd4, 32'h0);
    bus.raddr1 = 5'd3;
    bus.raddr2 = 5'd4;
    expect_v("dual_rdata1",  0, 32'hFFFF_FFFF);
    expect_v("dual_rdata2",  1, 32'h0);
    expect_v("mux_sel0",     3, 32'hFFFF_FFFF);
    mux_sel = 1'b1;
    expect_v("mux_sel1",     3, 32'h0);
    bus.raddr2 = 5'd3;
    expect_v("same_addr_b",  1, 32'hFFFF_FFFF);
    expect_v("same_addr_a",  0, 32'hFFFF_FFFF);

    @(negedge clk);
    bus.waddr = 5'd3;
    bus.wdata = 32'h0000_0123;
    @(negedge clk);
    bus.we = 1'bx;
    @(negedge clk);
    bus.we = 1'b0;
    expect_v("we_low_hold",  0, 32'hFFFF_FFFF);
    expect_v("we_low_count", 2, 32'd5);

    bus.raddr2 = 5'd5;
    @(negedge clk);
    #2 reset = 1'b1;
    expect_v("async_rst_rdata1", 0, 32'h0);
    expect_v("async_rst_rdata2", 1, 32'h0);
    expect_v("async_rst_count",  2, 32'h0);

    bus.we     = 1'b1;
    bus.waddr  = 5'd9;
    bus.wdata  = 32'hA5A5_A5A5;
    bus.raddr1 = 5'd9;
    expect_v("rst_write_no_fwd", 0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    bus.we = 1'b0;
    expect_v("collision_rdata1", 0, 32'h0);
    expect_v("collision_count",  2, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    bus.we     = 1'b1;
    bus.waddr  = 5'd10;
    bus.wdata  = 32'h1234_5678;
    @(negedge clk);
    bus.we     = 1'b0;
    bus.raddr2 = 5'd10;
    expect_v("first_write_data",  1, 32'h1234_5678);
    expect_v("first_write_count", 2, 32'd1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      #1;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
